// File: rtl/lp_result_collector.sv
// Collects one result per lane into a row, then replays the row as a serial stream, lane 0 first.
// Define LP_COLLECTOR_ERR_STICKY_EN to make err_unaligned_last hold until reset instead of pulsing.
module lp_result_collector #(
  parameter int PE_NUMBER_I     = 4,
  parameter int DATA_WIDTH_U_D  = 16,
  parameter int DATA_WIDTH_RSLT = 16,
  parameter int ID_WIDTH        = 1,
  parameter int DEST_WIDTH      = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PE_NUMBER_I*DATA_WIDTH_U_D-1:0] s_axis_tdata,
  input  logic [PE_NUMBER_I-1:0]              s_axis_tvalid,
  output logic [PE_NUMBER_I-1:0]              s_axis_tready,
  input  logic [PE_NUMBER_I-1:0]              s_axis_tlast,
  input  logic [PE_NUMBER_I*ID_WIDTH-1:0]     s_axis_tid,
  input  logic [PE_NUMBER_I*DEST_WIDTH-1:0]   s_axis_tdest,
  output logic [DATA_WIDTH_RSLT-1:0]          m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [ID_WIDTH-1:0]                 m_axis_tid,
  output logic [DEST_WIDTH-1:0]               m_axis_tdest,
  output logic                                err_unaligned_last
);

  localparam int IDX_W = (PE_NUMBER_I > 1) ? $clog2(PE_NUMBER_I) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PE_NUMBER_I - 1);

  typedef enum logic {CAPTURE, EMIT} state_t;

  state_t                            state_reg, state_next;
  logic                              run_reg;
  logic [PE_NUMBER_I-1:0]            captured_reg, captured_next, captured_fill;
  logic [PE_NUMBER_I-1:0]            lane_last_reg, lane_last_next, lane_hs;
  logic [PE_NUMBER_I*DATA_WIDTH_U_D-1:0] row_flat;
  logic [ID_WIDTH-1:0]               id_reg;
  logic [DEST_WIDTH-1:0]             dest_reg;
  logic [IDX_W-1:0]                  idx_reg, idx_next;
  logic                              err_reg, err_next;
  logic                              row_full, last_mismatch, emit_active;

  generate
    if (DATA_WIDTH_RSLT > DATA_WIDTH_U_D) begin : g_width_check
      $error("DATA_WIDTH_RSLT must not exceed DATA_WIDTH_U_D");
    end
    // Only lane 0 sideband reaches the output; other lanes are deliberately dropped.
    if (PE_NUMBER_I > 1) begin : g_unused
      logic unused_lane_sideband;
      assign unused_lane_sideband = ^{s_axis_tid[PE_NUMBER_I*ID_WIDTH-1:ID_WIDTH],
                                      s_axis_tdest[PE_NUMBER_I*DEST_WIDTH-1:DEST_WIDTH]};
    end
  endgenerate

  // run_reg keeps tready low until the first edge after reset release.
  assign s_axis_tready = (run_reg && state_reg == CAPTURE) ? ~captured_reg : '0;
  assign lane_hs       = s_axis_tvalid & s_axis_tready;
  assign captured_fill = captured_reg | lane_hs;
  assign lane_last_next = (lane_last_reg & ~lane_hs) | (s_axis_tlast & lane_hs);
  assign row_full      = (state_reg == CAPTURE) && (&captured_fill);
  assign last_mismatch = (|lane_last_next) && !(&lane_last_next);
  assign emit_active   = (state_reg == EMIT);

  genvar gi;
  generate
    for (gi = 0; gi < PE_NUMBER_I; gi++) begin : g_lane
      logic [DATA_WIDTH_U_D-1:0] data_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
        end else if (lane_hs[gi]) begin
          data_reg <= s_axis_tdata[gi*DATA_WIDTH_U_D +: DATA_WIDTH_U_D];
        end
      end
      assign row_flat[gi*DATA_WIDTH_U_D +: DATA_WIDTH_U_D] = data_reg;
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    captured_next = captured_fill;
    case (state_reg)
      CAPTURE: if (row_full) state_next = EMIT;
      EMIT: begin
        if (m_axis_tready) begin
          if (idx_reg == IDX_LAST) begin
            idx_next      = '0;
            captured_next = '0;
            state_next    = CAPTURE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = CAPTURE;
    endcase
`ifdef LP_COLLECTOR_ERR_STICKY_EN
    err_next = err_reg | (row_full & last_mismatch);
`else
    err_next = row_full & last_mismatch;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= CAPTURE;
      run_reg       <= 1'b0;
      captured_reg  <= '0;
      lane_last_reg <= '0;
      idx_reg       <= '0;
      id_reg        <= '0;
      dest_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      run_reg       <= 1'b1;
      captured_reg  <= captured_next;
      lane_last_reg <= lane_last_next;
      idx_reg       <= idx_next;
      err_reg       <= err_next;
      if (lane_hs[0]) begin
        id_reg   <= s_axis_tid[ID_WIDTH-1:0];
        dest_reg <= s_axis_tdest[DEST_WIDTH-1:0];
      end
    end
  end

  assign m_axis_tvalid = emit_active;
  assign m_axis_tdata  = emit_active ? row_flat[int'(idx_reg)*DATA_WIDTH_U_D +: DATA_WIDTH_RSLT] : '0;
  assign m_axis_tlast  = emit_active && (idx_reg == IDX_LAST) && (|lane_last_reg);
  assign m_axis_tid    = emit_active ? id_reg : '0;
  assign m_axis_tdest  = emit_active ? dest_reg : '0;
  assign err_unaligned_last = err_reg;

endmodule

// File: tb/tb_lp_result_collector.sv
// Randomized bench for lp_result_collector: rows are fed per lane, a beat queue predicts the stream.
module tb_lp_result_collector;
  localparam int N  = 4;
  localparam int WD = 24;
  localparam int WR = 16;
  localparam int IW = 2;
  localparam int DW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N*WD-1:0] s_data;
  logic [N-1:0]    s_valid, s_ready, s_last;
  logic [N*IW-1:0] s_id;
  logic [N*DW-1:0] s_dest;
  logic [WR-1:0]   m_data;
  logic            m_valid, m_ready, m_last, err;
  logic [IW-1:0]   m_id;
  logic [DW-1:0]   m_dest;

  always #5 clk = ~clk;

  lp_result_collector #(
    .PE_NUMBER_I(N), .DATA_WIDTH_U_D(WD), .DATA_WIDTH_RSLT(WR), .ID_WIDTH(IW), .DEST_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tlast(s_last), .s_axis_tid(s_id), .s_axis_tdest(s_dest),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last), .m_axis_tid(m_id), .m_axis_tdest(m_dest),
    .err_unaligned_last(err)
  );

  typedef struct packed {
    logic [WR-1:0] data;
    logic          last;
    logic [IW-1:0] id;
    logic [DW-1:0] dest;
    logic          mism;
    logic          first;
  } beat_t;

  int n_tests = 0;
  int n_fail  = 0;
  beat_t exp_q[$];
  logic [WR-1:0] obs_data[$];
  logic          obs_last[$];
  int err_rises = 0;
  int ready_mode = 0;
  int rdy_phase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // A row of lanes produces N beats: truncated lane data in order, tlast only on the final beat.
  function automatic void push_row(input logic [N*WD-1:0] d, input logic [N-1:0] tl,
                                   input logic [IW-1:0] id0, input logic [DW-1:0] dest0);
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.data  = d[k*WD +: WR];
      b.last  = (k == N-1) && (tl != '0);
      b.id    = id0;
      b.dest  = dest0;
      b.mism  = (tl != '0) && (tl != '1);
      b.first = (k == 0);
      exp_q.push_back(b);
    end
  endfunction

  task automatic drive_row(input logic [N*WD-1:0] data, input logic [N-1:0] tl,
                           input logic [N*IW-1:0] ids, input logic [N*DW-1:0] dests,
                           input logic [N*8-1:0] dly, output int cycles);
    logic [N-1:0] done, hs;
    done = '0;
    cycles = 0;
    while (done != '1 && cycles < 2000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) s_valid[i] = !done[i] && (cycles >= int'(dly[i*8 +: 8]));
      s_data = data; s_last = tl; s_id = ids; s_dest = dests;
      #1;
      for (int i = 0; i < N; i++) if (done[i]) check($sformatf("lane%0d_ready_after_hs", i), s_ready[i], 1'b0);
      hs = s_valid & s_ready;
      done = done | hs;
      cycles++;
    end
    check("row_capture_in_budget", done, {N{1'b1}});
    push_row(data, tl, ids[IW-1:0], dests[DW-1:0]);
    @(negedge clk);
    s_valid = '0;
    #1;
    check("first_beat_latency", m_valid, 1'b1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 500) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("drain_in_budget", (exp_q.size() == 0 && !m_valid), 1'b1);
  endtask

  initial begin
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin m_ready = (rdy_phase % 3 == 0); rdy_phase++; end
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Cycle-by-cycle compare of the output stream against the beat queue.
  initial begin
    logic pv, pstall, pe, sticky, exp_err;
    logic [WR-1:0] p_data;
    logic p_last;
    logic [IW-1:0] p_id;
    logic [DW-1:0] p_dest;
    beat_t e;
    pv = 0; pstall = 0; pe = 0; sticky = 0;
    p_data = '0; p_last = 0; p_id = '0; p_dest = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        check("reset_outputs", {m_valid, m_last, err, m_data, m_id, m_dest}, 0);
        check("reset_s_ready", s_ready, 0);
        pv = 0; pstall = 0; pe = 0; sticky = 0;
        continue;
      end
      exp_err = 1'b0;
      if (m_valid) begin
        if (pstall) begin
          check("hold_data", m_data, p_data);
          check("hold_ctrl", {m_last, m_id, m_dest}, {p_last, p_id, p_dest});
        end
        check("all_s_ready_low_in_emit", s_ready, 0);
        check("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          check("m_tdata", m_data, e.data);
          check("m_tlast", m_last, e.last);
          check("m_tid", m_id, e.id);
          check("m_tdest", m_dest, e.dest);
          if (!pv) begin
            check("row_starts_at_lane0", e.first, 1'b1);
            exp_err = e.mism;
          end
          if (m_ready) begin
            void'(exp_q.pop_front());
            obs_data.push_back(m_data);
            obs_last.push_back(m_last);
            $display("[TB] beat %0d data=%h last=%b id=%0d dest=%0d", obs_data.size()-1, m_data, m_last, m_id, m_dest);
          end
        end
      end else begin
        check("idle_tlast", m_last, 1'b0);
      end
      sticky = sticky | exp_err;
`ifdef LP_COLLECTOR_ERR_STICKY_EN
      check("err_unaligned_last", err, sticky);
`else
      check("err_unaligned_last", err, exp_err);
`endif
      if (err && !pe) err_rises++;
      pe = err;
      pv = m_valid;
      pstall = m_valid && !m_ready;
      p_data = m_data; p_last = m_last; p_id = m_id; p_dest = m_dest;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, base, er0, t;
    logic [N*WD-1:0] d;
    logic [N-1:0] tl;
    logic [N*IW-1:0] ids;
    logic [N*DW-1:0] dests;
    logic [N*8-1:0] dly;
    rst = 1'b1; s_valid = '0; s_data = '0; s_last = '0; s_id = '0; s_dest = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("ready_low_right_after_reset", s_ready, 0);
    @(negedge clk);
    #1 check("ready_up_after_first_edge", s_ready, {N{1'b1}});

    // Simultaneous lanes, data 1..4, unstalled sink.
    ready_mode = 0; base = obs_data.size(); er0 = err_rises;
    drive_row({24'd4, 24'd3, 24'd2, 24'd1}, 4'b0000, 8'h1B, 8'h2D, '0, cyc);
    wait_idle();
    for (int k = 0; k < N; k++) check($sformatf("t1_beat%0d", k), obs_data[base+k], k+1);
    check("t1_no_tlast", obs_last[base+3], 1'b0);
    check("t1_no_err", err_rises - er0, 0);

    // Staggered lanes: lane3 t0, lane0 t2, lane1 t5, lane2 t6.
    base = obs_data.size();
    drive_row({24'h000040, 24'h000030, 24'h000020, 24'h000010}, 4'b0000, 8'h00, 8'h00,
              {8'd0, 8'd6, 8'd5, 8'd2}, cyc);
    check("t2_capture_cycles", cyc, 7);
    wait_idle();
    check("t2_order", {obs_data[base], obs_data[base+1], obs_data[base+2], obs_data[base+3]},
          {16'h10, 16'h20, 16'h30, 16'h40});

    // Sink ready pattern 1,0,0,1,...
    ready_mode = 1; base = obs_data.size();
    drive_row({24'd40, 24'd30, 24'd20, 24'd10}, 4'b0000, 8'h00, 8'h00, '0, cyc);
    wait_idle();
    check("t3_count", obs_data.size() - base, N);
    for (int k = 0; k < N; k++) check($sformatf("t3_beat%0d", k), obs_data[base+k], 10*(k+1));

    // Aligned tlast, then unaligned {1,0,1,0}.
    ready_mode = 0; base = obs_data.size(); er0 = err_rises;
    drive_row({24'd8, 24'd7, 24'd6, 24'd5}, 4'b1111, 8'h00, 8'h00, '0, cyc);
    wait_idle();
    check("t4_last_beat3", obs_last[base+3], 1'b1);
    check("t4_no_last_beat0", obs_last[base], 1'b0);
    check("t4_aligned_no_err", err_rises - er0, 0);
    base = obs_data.size();
    drive_row({24'd8, 24'd7, 24'd6, 24'd5}, 4'b1010, 8'h00, 8'h00, '0, cyc);
    wait_idle();
    check("t4_unaligned_err", err_rises - er0, 1);
    check("t4_unaligned_last", obs_last[base+3], 1'b1);

    // Truncation to the low result bits.
    base = obs_data.size();
    drive_row({24'h000000, 24'h000000, 24'h123456, 24'hABCDEF}, 4'b0000, 8'h00, 8'h00, '0, cyc);
    wait_idle();
    check("t5_trunc_lane0", obs_data[base], 16'hCDEF);
    check("t5_trunc_lane1", obs_data[base+1], 16'h3456);

    // Randomized rows.
    ready_mode = 2;
    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < N; i++) begin
        d[i*WD +: WD] = WD'($urandom);
        dly[i*8 +: 8] = 8'($urandom_range(0, 4));
      end
      case ($urandom_range(0, 2))
        0: tl = '0;
        1: tl = '1;
        default: tl = N'($urandom);
      endcase
      ids = N*IW'($urandom);
      dests = N*DW'($urandom);
      drive_row(d, tl, ids, dests, dly, cyc);
    end
    wait_idle();

    // Reset after two of four lanes are captured.
    ready_mode = 0;
    @(negedge clk);
    s_data = {24'h0, 24'h0, 24'h00BEEF, 24'h00DEAD}; s_valid = 4'b0011;
    #1 check("partial_ready_before", s_ready, 4'b1111);
    @(negedge clk);
    s_valid = '0;
    #1 check("partial_ready_after", s_ready, 4'b1100);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rst1_ready_low", s_ready, 0);
    @(negedge clk);
    #1 check("rst1_ready_up", s_ready, {N{1'b1}});
    base = obs_data.size();
    drive_row({24'h44, 24'h33, 24'h22, 24'h11}, 4'b0000, 8'h00, 8'h00, '0, cyc);
    wait_idle();
    check("rst1_clean_row", {obs_data[base], obs_data[base+1], obs_data[base+2], obs_data[base+3]},
          {16'h11, 16'h22, 16'h33, 16'h44});

    // Reset while beat 2 of the row is on the output.
    base = obs_data.size();
    drive_row({24'h99, 24'h88, 24'h77, 24'h66}, 4'b1111, 8'h00, 8'h00, '0, cyc);
    t = 0;
    while (obs_data.size() < base + 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rst2_valid_low", m_valid, 1'b0);
    repeat (5) @(negedge clk);
    #2 check("rst2_no_stale_beats", obs_data.size() - base, 2);
    base = obs_data.size();
    drive_row({24'h5D, 24'h5C, 24'h5B, 24'h5A}, 4'b0000, 8'h00, 8'h00, '0, cyc);
    wait_idle();
    check("rst2_clean_row", {obs_data[base], obs_data[base+1], obs_data[base+2], obs_data[base+3]},
          {16'h5A, 16'h5B, 16'h5C, 16'h5D});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
